// File: rtl/sc_backg_shift_ctrl.sv
// Command-side sequencer for the background-pattern register: clear, load the
// fixed pattern, then issue timed one-cycle shift commands until stopped.
//
//   state   | meaning
//   IDLE    | waiting for start, level tracked silently
//   CLEAR   | clear strobe to the register, counters reset
//   LOAD    | load strobe with the fixed pattern on the data bus
//   RUN     | prescaler running, shift command at terminal count
//   PAUSE   | prescaler and ping-pong step count frozen
module sc_backg_shift_ctrl #(
  parameter int                         BACKG_DATAWIDTH    = 8,
  parameter int                         PRESC_WIDTH        = 24,
  parameter logic [PRESC_WIDTH-1:0]     SHIFT_PERIOD       = 24'd5000000,
  parameter logic [BACKG_DATAWIDTH-1:0] DATA_FIXED_PATTERN = 8'b00011000
) (
  input  logic                       SC_BACKGCTRL_CLOCK_50,
  input  logic                       SC_BACKGCTRL_RESET_InHigh,
  input  logic                       SC_BACKGCTRL_start_InLow,
  input  logic                       SC_BACKGCTRL_stop_InLow,
  input  logic                       SC_BACKGCTRL_pause_InLow,
  input  logic [1:0]                 SC_BACKGCTRL_mode_InBUS,
  input  logic [1:0]                 SC_BACKGCTRL_level_InBUS,
  output logic                       SC_BACKGCTRL_clear_OutLow,
  output logic                       SC_BACKGCTRL_load_OutLow,
  output logic [1:0]                 SC_BACKGCTRL_shiftselection_OutBUS,
  output logic [BACKG_DATAWIDTH-1:0] SC_BACKGCTRL_data_OutBUS,
  output logic                       SC_BACKGCTRL_transition_Out,
  output logic                       SC_BACKGCTRL_busy_Out
);

  localparam int                     STEP_W     = $clog2(BACKG_DATAWIDTH);
  localparam logic [PRESC_WIDTH-1:0] PRESC_LAST = SHIFT_PERIOD - PRESC_WIDTH'(1);
  localparam logic [STEP_W-1:0]      STEP_LAST  = STEP_W'(BACKG_DATAWIDTH - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_RUN,
    S_PAUSE
  } state_t;

  state_t                 state_q, state_d;
  logic [PRESC_WIDTH-1:0] presc_q, presc_d, presc_next;
  logic [STEP_W-1:0]      stepcnt_q, stepcnt_d;
  logic                   pp_dir_q, pp_dir_d;
  logic [1:0]             level_q, level_d;
  logic [1:0]             shiftsel_q, shiftsel_d;
  logic                   transition_q, transition_d;
  logic [1:0]             shift_code;

  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    stepcnt_d    = stepcnt_q;
    pp_dir_d     = pp_dir_q;
    level_d      = level_q;
    shiftsel_d   = 2'b00;
    transition_d = 1'b0;
    presc_next   = (presc_q == PRESC_LAST) ? '0 : presc_q + PRESC_WIDTH'(1);

    case (SC_BACKGCTRL_mode_InBUS)
      2'b01:   shift_code = 2'b01;
      2'b10:   shift_code = 2'b10;
      2'b11:   shift_code = pp_dir_q ? 2'b10 : 2'b01;
      default: shift_code = 2'b00;
    endcase

    // pp_dir 0 = left; counters restart on every pass through CLEAR
    if (state_q == S_CLEAR) begin
      presc_d   = '0;
      stepcnt_d = '0;
      pp_dir_d  = 1'b0;
    end

    if (state_q == S_IDLE) begin
      level_d = SC_BACKGCTRL_level_InBUS;
      if (!SC_BACKGCTRL_start_InLow) state_d = S_CLEAR;
    end else if (SC_BACKGCTRL_level_InBUS != level_q) begin
      level_d      = SC_BACKGCTRL_level_InBUS;
      transition_d = 1'b1;
      state_d      = S_CLEAR;
    end else if (!SC_BACKGCTRL_stop_InLow) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_CLEAR: state_d = S_LOAD;
        S_LOAD:  state_d = S_RUN;
        S_RUN: begin
          if (!SC_BACKGCTRL_pause_InLow) begin
            state_d = S_PAUSE;
          end else begin
            presc_d = presc_next;
            // shift command is registered so it lines up with the terminal count
            if (presc_next == PRESC_LAST) begin
              shiftsel_d = shift_code;
              if (SC_BACKGCTRL_mode_InBUS == 2'b11) begin
                if (stepcnt_q == STEP_LAST) begin
                  stepcnt_d = '0;
                  pp_dir_d  = ~pp_dir_q;
                end else begin
                  stepcnt_d = stepcnt_q + STEP_W'(1);
                end
              end
            end
          end
        end
        S_PAUSE: if (SC_BACKGCTRL_pause_InLow) state_d = S_RUN;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge SC_BACKGCTRL_CLOCK_50) begin
    if (SC_BACKGCTRL_RESET_InHigh) begin
      state_q      <= S_IDLE;
      presc_q      <= '0;
      stepcnt_q    <= '0;
      pp_dir_q     <= 1'b0;
      level_q      <= SC_BACKGCTRL_level_InBUS;
      shiftsel_q   <= 2'b00;
      transition_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      stepcnt_q    <= stepcnt_d;
      pp_dir_q     <= pp_dir_d;
      level_q      <= level_d;
      shiftsel_q   <= shiftsel_d;
      transition_q <= transition_d;
    end
  end

  assign SC_BACKGCTRL_clear_OutLow          = (state_q != S_CLEAR);
  assign SC_BACKGCTRL_load_OutLow           = (state_q != S_LOAD);
  assign SC_BACKGCTRL_data_OutBUS           = (state_q == S_LOAD) ? DATA_FIXED_PATTERN : '0;
  assign SC_BACKGCTRL_shiftselection_OutBUS = shiftsel_q;
  assign SC_BACKGCTRL_transition_Out        = transition_q;
  assign SC_BACKGCTRL_busy_Out              = (state_q != S_IDLE);

endmodule

// File: tb/tb_sc_backg_shift_ctrl.sv
// Scoreboard bench for sc_backg_shift_ctrl: expected command events are derived
// from the start time, shift period, pause window and ping-pong run length.
module tb_sc_backg_shift_ctrl;
  localparam int         P     = 4;
  localparam int         W     = 8;
  localparam logic [7:0] PAT   = 8'h18;
  localparam int         NEVER = 32'h3fff_ffff;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_n = 1'b1, stop_n = 1'b1, pause_n = 1'b1;
  logic [1:0] mode = 2'b00, level = 2'b00;
  logic       clr_n, ld_n, tr, busy;
  logic [1:0] sel;
  logic [7:0] data;

  typedef struct {
    int         t;
    logic       clr_n;
    logic       ld_n;
    logic [7:0] data;
    logic [1:0] sel;
    logic       tr;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  checks = 0, failures = 0;
  int  cyc = 0;
  bit  mon_en = 1'b0;
  int  run0 = 0, pause_at = NEVER, pause_len = 0;
  int  c, it;
  logic [1:0] m;

  sc_backg_shift_ctrl #(.SHIFT_PERIOD(24'd4)) dut (
    .SC_BACKGCTRL_CLOCK_50             (clk),
    .SC_BACKGCTRL_RESET_InHigh         (rst),
    .SC_BACKGCTRL_start_InLow          (start_n),
    .SC_BACKGCTRL_stop_InLow           (stop_n),
    .SC_BACKGCTRL_pause_InLow          (pause_n),
    .SC_BACKGCTRL_mode_InBUS           (mode),
    .SC_BACKGCTRL_level_InBUS          (level),
    .SC_BACKGCTRL_clear_OutLow         (clr_n),
    .SC_BACKGCTRL_load_OutLow          (ld_n),
    .SC_BACKGCTRL_shiftselection_OutBUS(sel),
    .SC_BACKGCTRL_data_OutBUS          (data),
    .SC_BACKGCTRL_transition_Out       (tr),
    .SC_BACKGCTRL_busy_Out             (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: any cycle with a command on the register interface must match the queue head.
  always @(negedge clk) begin
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].t < cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_event expected_cyc=%0d sel=%b tr=%b clr_n=%b ld_n=%b now=%0d",
                 exp_q[0].t, exp_q[0].sel, exp_q[0].tr, exp_q[0].clr_n, exp_q[0].ld_n, cyc);
        mon_e = exp_q.pop_front();
      end
      if (!clr_n || !ld_n || sel != 2'b00 || tr || data != 8'h00) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event cyc=%0d clr_n=%b ld_n=%b data=%h sel=%b tr=%b required=none",
                   cyc, clr_n, ld_n, data, sel, tr);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.t != cyc || mon_e.clr_n !== clr_n || mon_e.ld_n !== ld_n ||
              mon_e.data !== data || mon_e.sel !== sel || mon_e.tr !== tr) begin
            failures++;
            $display("FAIL event actual: cyc=%0d clr_n=%b ld_n=%b data=%h sel=%b tr=%b required: cyc=%0d clr_n=%b ld_n=%b data=%h sel=%b tr=%b",
                     cyc, clr_n, ld_n, data, sel, tr,
                     mon_e.t, mon_e.clr_n, mon_e.ld_n, mon_e.data, mon_e.sel, mon_e.tr);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, req, cyc);
    end
  endtask

  task automatic push(input int t, input logic cl, input logic ld, input logic [7:0] d,
                      input logic [1:0] s, input logic x);
    ev_t e;
    e.t = t; e.clr_n = cl; e.ld_n = ld; e.data = d; e.sel = s; e.tr = x;
    exp_q.push_back(e);
  endtask

  // Ping-pong: W-1 shifts left, W-1 right, and so on.
  function automatic logic [1:0] code_of(input logic [1:0] md, input int k);
    if (md == 2'b11) return (((k / (W - 1)) % 2) == 1) ? 2'b10 : 2'b01;
    return md;
  endfunction

  // k-th shift after entering RUN; a pause of L low samples costs L+1 cycles.
  function automatic int shift_time(input int k);
    int t;
    t = run0 + P - 1 + k * P;
    if (t >= pause_at) t += pause_len + 1;
    return t;
  endfunction

  task automatic push_run(input logic [1:0] md, input int last_c);
    for (int k = 0; shift_time(k) <= last_c; k++)
      if (code_of(md, k) != 2'b00) push(shift_time(k), 1'b1, 1'b1, 8'h00, code_of(md, k), 1'b0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_clear"}, 32'(clr_n), 32'd1);
    chk({tag, "_load"},  32'(ld_n),  32'd1);
    chk({tag, "_sel"},   32'(sel),   32'd0);
    chk({tag, "_data"},  32'(data),  32'd0);
    chk({tag, "_trans"}, 32'(tr),    32'd0);
    chk({tag, "_busy"},  32'(busy),  32'd0);
  endtask

  task automatic begin_seq(input logic [1:0] md);
    mode = md;
    start_n = 1'b0;
    push(cyc + 1, 1'b0, 1'b1, 8'h00, 2'b00, 1'b0);
    push(cyc + 2, 1'b1, 1'b0, PAT, 2'b00, 1'b0);
    run0 = cyc + 3;
    pause_at = NEVER;
    pause_len = 0;
    @(negedge clk);
    start_n = 1'b1;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic run_until(input int end_cyc);
    while (cyc < end_cyc) begin
      pause_n = !((cyc + 1 >= pause_at) && (cyc + 1 < pause_at + pause_len));
      @(negedge clk);
    end
    pause_n = 1'b1;
  endtask

  task automatic end_stop();
    stop_n = 1'b0;
    @(negedge clk);
    stop_n = 1'b1;
    chk("busy_after_stop", 32'(busy), 32'd0);
  endtask

  task automatic end_level();
    level = level ^ 2'($urandom_range(1, 3));
    push(cyc + 1, 1'b0, 1'b1, 8'h00, 2'b00, 1'b1);
    push(cyc + 2, 1'b1, 1'b0, PAT, 2'b00, 1'b0);
    run0 = cyc + 3;
    pause_at = NEVER;
    pause_len = 0;
    @(negedge clk);
    chk("busy_after_level", 32'(busy), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_reset("por");
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // rotate-left: shifts at N+5, N+9, N+13
    begin_seq(2'b01);
    c = run0 - 2 + 13;
    push_run(2'b01, c);
    run_until(c);
    end_stop();
    @(negedge clk);

    // ping-pong through two direction changes
    begin_seq(2'b11);
    c = shift_time(15);
    push_run(2'b11, c);
    run_until(c);
    end_stop();
    @(negedge clk);

    // pause at presc=2 for 10 clocks
    begin_seq(2'b01);
    pause_at = run0 + 3;
    pause_len = 10;
    c = shift_time(2);
    push_run(2'b01, c);
    run_until(c);
    end_stop();
    @(negedge clk);

    // level change landing on a terminal cycle
    begin_seq(2'b10);
    c = shift_time(1) - 1;
    push_run(2'b10, c);
    run_until(c);
    end_level();
    c = shift_time(2);
    push_run(2'b10, c);
    run_until(c);
    end_stop();
    @(negedge clk);

    // stop while paused, then level change in IDLE
    begin_seq(2'b01);
    pause_at = run0 + 5;
    pause_len = 30;
    c = pause_at + 4;
    push_run(2'b01, c);
    run_until(c);
    end_stop();
    level = level ^ 2'b01;
    repeat (4) begin
      @(negedge clk);
      chk("idle_no_transition", 32'(tr), 32'd0);
    end
    chk("idle_busy", 32'(busy), 32'd0);

    // reset mid-RUN
    begin_seq(2'b01);
    c = run0 + 6;
    push_run(2'b01, c);
    run_until(c);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset("midrun");
    rst = 1'b0;
    @(negedge clk);

    for (it = 0; it < 10; it++) begin
      m = 2'($urandom_range(0, 3));
      begin_seq(m);
      if ($urandom_range(0, 1) == 1) begin
        pause_at = run0 + 1 + int'($urandom_range(0, 10));
        pause_len = int'($urandom_range(1, 8));
      end
      c = run0 + int'($urandom_range(4, 40));
      push_run(m, c);
      run_until(c);
      if ($urandom_range(0, 1) == 1) begin
        end_level();
        c = run0 + int'($urandom_range(4, 30));
        push_run(m, c);
        run_until(c);
      end
      end_stop();
      @(negedge clk);
    end

    repeat (3 * P) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
